merge_heads_stream: RTL
=======================

Name: merge_heads_stream

Overview:
- Inverse of the head-split reshape. Gathers per-head slices of one token, each DATA_WIDTH*HEAD_DIM bits, arriving as a valid/ready stream.
- Concatenates the NUM_HEADS slices into one full hidden-width row (SEQ_LEN x NUM_HEADS x HEAD_DIM -> SEQ_LEN x NUM_HEADS*HEAD_DIM).
- Emits the row on a valid/ready output stream, with a last-row flag per sequence.
- Sits after per-head attention, before the output projection.

Parameters:
- DATA_WIDTH, 8, bits per element.
- SEQ_LEN, 128, tokens per sequence (rows per frame).
- NUM_HEADS, 12, heads merged per row.
- HEAD_DIM, 64, elements per head slice.
- HEAD_IDX_WIDTH, 4, width of head index tag; must satisfy 2^HEAD_IDX_WIDTH >= NUM_HEADS.
- TOK_CNT_WIDTH, 7, token counter width; must satisfy 2^TOK_CNT_WIDTH >= SEQ_LEN.

Ports:
- clk_p  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input slice valid.
- in_ready  out  1  block accepts slice.
- in_data  in  DATA_WIDTH*HEAD_DIM  one head slice of one token; element 0 in LSBs.
- in_head  in  HEAD_IDX_WIDTH  head index tag of the slice.
- out_valid  out  1  merged row valid.
- out_ready  in  1  downstream accepts row.
- out_data  out  DATA_WIDTH*NUM_HEADS*HEAD_DIM  merged row.
- out_last  out  1  row is token SEQ_LEN-1 of the sequence.
- err_clr  in  1  synchronous clear of err_head.
- err_head  out  1  sticky head-order error.
- busy  out  1  head_cnt != 0 or state == HOLD.

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT; head_cnt=0; tok_cnt=0.
  - out_valid=0, out_last=0, out_data=0, err_head=0.
  - Reset mid-row or mid-HOLD discards the partial or held row; no output appears after release.
- Handshakes:
  - Transfer occurs on the rising edge when valid && ready.
  - in_ready is combinational: 1 iff state==COLLECT. It does not depend on in_valid.
  - out_valid is registered.
- COLLECT:
  - On an input transfer, in_data is written to out_data slot head_cnt, i.e. bits [(head_cnt+1)*DATA_WIDTH*HEAD_DIM-1 : head_cnt*DATA_WIDTH*HEAD_DIM]. Head 0 occupies the LSBs, matching the split layout: row element h*HEAD_DIM+k = head h element k.
  - If head_cnt < NUM_HEADS-1: head_cnt increments.
  - If head_cnt == NUM_HEADS-1:
    - head_cnt returns to 0 and state becomes HOLD.
    - out_valid=1 and out_last=(tok_cnt==SEQ_LEN-1) are set on the same edge.
- HOLD:
  - in_ready=0; out_data, out_valid and out_last are held stable until the output transfer.
  - On an output transfer: out_valid=0, out_last=0, state returns to COLLECT.
  - tok_cnt increments, wrapping SEQ_LEN-1 -> 0.
- Latency and throughput:
  - The merged row is visible the cycle after the last head slice is accepted.
  - Best-case rate is one row per NUM_HEADS+1 cycles.
  - out_ready held low stalls indefinitely with no data loss.
- Stale data: out_data slots are not cleared between rows. Contents are meaningful only while out_valid=1.
- Head ordering:
  - Placement always follows head_cnt, not in_head.
  - A transfer with in_head != head_cnt sets err_head=1. The data is still stored and the row is still emitted.
- err_head:
  - Sticky until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Tags: in_head values >= NUM_HEADS always flag an error.

Optional Feature:
- Macro: MERGE_HEAD_CHECK_EN.
- Defined: in_head is compared against head_cnt and err_head behaves as above.
- Undefined:
  - in_head is ignored; no comparator is built.
  - err_head is tied to 0; err_clr is ignored.
  - Data path and timing are identical.

Test Plan:
- Single row: 12 slices, tags 0..11, slice h filled with byte h, out_ready=1. Required:
  - out_valid rises the cycle after the 12th transfer.
  - out_data byte 64*h+k == h.
  - out_last=0; err_head=0.
  - in_ready=0 for exactly 1 cycle.
- Backpressure: out_ready=0 for 20 cycles after row complete. Required:
  - in_ready=0 throughout.
  - out_data/out_last stable.
  - Row accepted on the first cycle out_ready=1; in_ready=1 on the next cycle.
- Frame wrap: 128 rows back-to-back, each row tagged with its token number in element 0. Required:
  - out_last=1 only on row 127.
  - Row 128 (next frame) has out_last=0.
  - tok_cnt wraps to 0.
- Head-order error (MERGE_HEAD_CHECK_EN defined): 3rd slice tagged 5. Required:
  - err_head=1 from the next cycle.
  - Slice still lands in slot 2; row emitted normally.
  - err_clr pulse clears err_head.
  - Repeat with the macro undefined: err_head stays 0.
- Input gaps: in_valid toggled randomly at 50%. Required: the merged row equals the gap-free case; busy=1 from the first accepted slice until the row transfer.
- Async reset after 6 slices: rst_n low for 2 cycles, then a full row tagged 0..11. Required:
  - The first output row contains only post-reset slices.
  - tok_cnt=0 and out_last=0.
  - Outputs are 0 during reset.

Source files
------------

// File: rtl/merge_heads_stream.sv
// Gathers NUM_HEADS head slices per token into one hidden-width row; row visible 1 cycle after last slice.
// in_ready drops while a row is held until out_ready; define MERGE_HEAD_CHECK_EN to build the head-order check.
module merge_heads_stream #(
  parameter int DATA_WIDTH     = 8,
  parameter int SEQ_LEN        = 128,
  parameter int NUM_HEADS      = 12,
  parameter int HEAD_DIM       = 64,
  parameter int HEAD_IDX_WIDTH = 4,
  parameter int TOK_CNT_WIDTH  = 7
) (
  input  logic                                     clk_p,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_WIDTH*HEAD_DIM-1:0]           in_data,
  input  logic [HEAD_IDX_WIDTH-1:0]                in_head,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH*NUM_HEADS*HEAD_DIM-1:0] out_data,
  output logic                                     out_last,
  input  logic                                     err_clr,
  output logic                                     err_head,
  output logic                                     busy
);

  localparam int SLICE_W = DATA_WIDTH * HEAD_DIM;
  localparam int ROW_W   = SLICE_W * NUM_HEADS;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  localparam logic [HEAD_IDX_WIDTH-1:0] LAST_HEAD = HEAD_IDX_WIDTH'(NUM_HEADS - 1);
  localparam logic [TOK_CNT_WIDTH-1:0]  LAST_TOK  = TOK_CNT_WIDTH'(SEQ_LEN - 1);

  logic [0:0]                r_state;
  logic [HEAD_IDX_WIDTH-1:0] r_head_cnt;
  logic [TOK_CNT_WIDTH-1:0]  r_tok_cnt;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic [ROW_W-1:0]          r_out_data;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_row_done;

  assign in_ready   = (r_state == ST_COLLECT);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_row_done = w_in_xfer && (r_head_cnt == LAST_HEAD);

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_COLLECT;
      r_head_cnt  <= '0;
      r_tok_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        if (w_row_done) begin
          r_head_cnt  <= '0;
          r_state     <= ST_HOLD;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_tok_cnt == LAST_TOK);
        end else begin
          r_head_cnt <= r_head_cnt + 1'b1;
        end
      end
      // Input and output transfers are exclusive: out_valid only exists in HOLD.
      if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_state     <= ST_COLLECT;
        r_tok_cnt   <= (r_tok_cnt == LAST_TOK) ? '0 : r_tok_cnt + 1'b1;
      end
    end
  end

  // Slot choice follows head_cnt only; the tag never steers placement.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (w_in_xfer) begin
      for (int h = 0; h < NUM_HEADS; h++) begin
        if (r_head_cnt == HEAD_IDX_WIDTH'(h)) begin
          r_out_data[h*SLICE_W +: SLICE_W] <= in_data;
        end
      end
    end
  end

`ifdef MERGE_HEAD_CHECK_EN
  logic r_err_head;
  logic w_err_set;

  assign w_err_set = w_in_xfer && (in_head != r_head_cnt);

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_err_head <= 1'b0;
    end else if (w_err_set) begin
      r_err_head <= 1'b1;
    end else if (err_clr) begin
      r_err_head <= 1'b0;
    end
  end

  assign err_head = r_err_head;
`else
  logic w_unused_err;

  assign w_unused_err = ^{in_head, err_clr};
  assign err_head     = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign busy      = (r_head_cnt != '0) || (r_state == ST_HOLD);

endmodule
